cpu_clock_ctrl: RTL

//   Upstream of the board top: turns raw CLK and BUTTON into the CPU's slow CLOCK, a one-cycle TICK

---
 rtl/cpu_clock_pkg.sv | 19 +
 rtl/cpu_clock_ctrl_if.sv | 23 ++
 rtl/cpu_clock_ctrl_button_debounce.sv | 41 ++++
 rtl/cpu_clock_ctrl.sv | 111 +++++++++++
 4 files changed

// File: rtl/cpu_clock_pkg.sv
// Shared types and defaults for the CPU clock/reset controller.
package cpu_clock_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    HOLD  = 2'd2
  } press_state_e;

  localparam int PAR_CLOCK      = 100_000_000;
  localparam int PAR_DEBOUNCE   = 1_000_000;
  localparam int PAR_LONG_PRESS = 100_000_000;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cpu_clock_ctrl_if.sv
// Button/mode inputs and CPU clock/reset outputs of cpu_clock_ctrl, plus FSM debug state.
interface cpu_clock_ctrl_if;
  import cpu_clock_pkg::*;

  logic         BUTTON;
  logic         MODE;
  logic         CLOCK;
  logic         TICK;
  logic         CPU_RESET;
  logic         BUTTON_DB;
  press_state_e FSM_STATE;

  modport master (
    output BUTTON, MODE,
    input  CLOCK, TICK, CPU_RESET, BUTTON_DB, FSM_STATE
  );

  modport slave (
    input  BUTTON, MODE,
    output CLOCK, TICK, CPU_RESET, BUTTON_DB, FSM_STATE
  );

endinterface

// File: rtl/cpu_clock_ctrl_button_debounce.sv
// Two-flop synchroniser followed by a stable-count filter for a raw push-button.
module button_debounce
  import cpu_clock_pkg::*;
#(
  parameter int DEBOUNCE = PAR_DEBOUNCE
) (
  input  logic CLK,
  input  logic RESET,
  input  logic BUTTON,
  output logic BUTTON_DB
);

  localparam int             W    = cnt_width(DEBOUNCE);
  localparam logic [W-1:0]   LAST = W'(DEBOUNCE - 1);

  logic         sync_a;
  logic         btn_s;
  logic [W-1:0] deb_cnt;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync_a    <= 1'b0;
      btn_s     <= 1'b0;
      deb_cnt   <= '0;
      BUTTON_DB <= 1'b0;
    end else begin
      sync_a <= BUTTON;
      btn_s  <= sync_a;
      // Any return to the current level restarts the stability count.
      if (btn_s == BUTTON_DB) begin
        deb_cnt <= '0;
      end else if (deb_cnt == LAST) begin
        BUTTON_DB <= btn_s;
        deb_cnt   <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cpu_clock_ctrl.sv
// Slow CPU clock divider with TICK enable and long-press CPU reset.
// Define CPU_CLOCK_CTRL_STEP_EN to enable single-step mode (MODE=1, short press = one CPU clock).
module cpu_clock_ctrl
  import cpu_clock_pkg::*;
#(
  parameter int PERIOD     = PAR_CLOCK,
  parameter int DEBOUNCE   = PAR_DEBOUNCE,
  parameter int LONG_PRESS = PAR_LONG_PRESS
) (
  input  logic             CLK,
  input  logic             RESET,
  cpu_clock_ctrl_if.slave  bus
);

  localparam int              DW      = cnt_width(PERIOD);
  localparam int              HW      = cnt_width(LONG_PRESS);
  localparam logic [DW-1:0]   HALF    = DW'(PERIOD / 2);
  localparam logic [DW-1:0]   LAST    = DW'(PERIOD - 1);
  localparam logic [HW-1:0]   HOLD_AT = HW'(LONG_PRESS - 1);

  press_state_e  state, state_next;
  logic [HW-1:0] hold_cnt, hold_next;
  logic [DW-1:0] div_cnt, div_next;
  logic          step;
  logic          button_db;
  logic          clock_q, tick_q, cpu_reset_q;

  button_debounce #(.DEBOUNCE(DEBOUNCE)) u_debounce (
    .CLK       (CLK),
    .RESET     (RESET),
    .BUTTON    (bus.BUTTON),
    .BUTTON_DB (button_db)
  );

  assign bus.BUTTON_DB = button_db;
  assign bus.FSM_STATE = state;
  assign bus.CLOCK     = clock_q;
  assign bus.TICK      = tick_q;
  assign bus.CPU_RESET = cpu_reset_q;

  always_comb begin
    state_next = state;
    hold_next  = hold_cnt;
    step       = 1'b0;
    case (state)
      IDLE: begin
        if (button_db) begin
          state_next = PRESS;
          hold_next  = '0;
        end
      end
      PRESS: begin
        if (hold_cnt != HOLD_AT) hold_next = hold_cnt + 1'b1;
        // Release wins over reaching the long-press threshold.
        if (!button_db) begin
          state_next = IDLE;
          step       = 1'b1;
        end else if (hold_cnt == HOLD_AT) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (!button_db) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef CPU_CLOCK_CTRL_STEP_EN
  logic mode_q;
  logic mode_eff;

  // MODE is only adopted while the divider sits at zero.
  assign mode_eff = (div_cnt == '0) ? bus.MODE : mode_q;

  always_ff @(posedge CLK) begin
    if (RESET) mode_q <= 1'b0;
    else       mode_q <= mode_eff;
  end
`else
  logic unused_step_mode;
  assign unused_step_mode = step ^ bus.MODE;
`endif

  always_comb begin
    div_next = (div_cnt == LAST) ? '0 : div_cnt + 1'b1;
`ifdef CPU_CLOCK_CTRL_STEP_EN
    if (mode_eff && (div_cnt == '0)) div_next = step ? HALF : '0;
`endif
    if (state_next == HOLD) div_next = '0;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= IDLE;
      hold_cnt    <= '0;
      div_cnt     <= '0;
      clock_q     <= 1'b0;
      tick_q      <= 1'b0;
      cpu_reset_q <= 1'b0;
    end else begin
      state       <= state_next;
      hold_cnt    <= hold_next;
      div_cnt     <= div_next;
      clock_q     <= (div_next >= HALF);
      tick_q      <= (div_next == HALF);
      cpu_reset_q <= (state_next == HOLD);
    end
  end

endmodule
